// File: rtl/t03_sram_ctrl.sv
// Request/response front end for the 32x1024 dual-port SRAM macro (port 0 write, port 1 read).
// Handles one byte-addressed request at a time, with read-modify-write for partial byte writes.
module t03_sram_ctrl #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_sel,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_CAP, RMW_ISSUE, RMW_CAP, WR_ISSUE, RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  csb0_q, csb0_d;
  logic                  csb1_q, csb1_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            sel_q, sel_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  addr_err;

  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [3:0] sel);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{sel[i]}};
    return m;
  endfunction

  assign word_idx = req_addr[ADDR_WIDTH+1:2];
  assign addr_err = (req_addr[1:0] != 2'b00) ||
                    (req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);

  always_comb begin
    state_d      = state_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    csb0_d       = 1'b1;
    csb1_d       = 1'b1;
    addr0_d      = addr0_q;
    addr1_d      = addr1_q;
    din0_d       = din0_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          wdata_d     = req_wdata;
          sel_d       = req_sel;
          if (addr_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we && req_sel == 4'h0) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else if (req_we && req_sel == 4'hF) begin
            state_d = WR_ISSUE;
            csb0_d  = 1'b0;
            addr0_d = word_idx;
            din0_d  = req_wdata;
          end else if (req_we) begin
            // Partial write: fetch the old word first, write the merge later.
            state_d = RMW_ISSUE;
            csb1_d  = 1'b0;
            addr1_d = word_idx;
            addr0_d = word_idx;
          end else begin
            state_d = RD_ISSUE;
            csb1_d  = 1'b0;
            addr1_d = word_idx;
          end
        end
      end
      RD_ISSUE:  state_d = RD_CAP;
      RD_CAP: begin
        // dout1 is only valid up to this edge; it goes X right after.
        resp_rdata_d = sram_dout1;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RMW_ISSUE: state_d = RMW_CAP;
      RMW_CAP: begin
        csb0_d  = 1'b0;
        din0_d  = (sram_dout1 & ~byte_mask(sel_q)) | (wdata_q & byte_mask(sel_q));
        state_d = WR_ISSUE;
      end
      WR_ISSUE: begin
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      csb0_q       <= 1'b1;
      csb1_q       <= 1'b1;
      addr0_q      <= '0;
      addr1_q      <= '0;
      din0_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      csb0_q       <= csb0_d;
      csb1_q       <= csb1_d;
      addr0_q      <= addr0_d;
      addr1_q      <= addr1_d;
      din0_q       <= din0_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign sram_csb0  = csb0_q;
  assign sram_csb1  = csb1_q;
  assign sram_addr0 = addr0_q;
  assign sram_addr1 = addr1_q;
  assign sram_din0  = din0_q;

endmodule

// File: tb/tb_t03_sram_ctrl.sv
// Bench for t03_sram_ctrl: behavioural SRAM macro model plus a response scoreboard.
module tb_t03_sram_ctrl;
  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        sram_csb0, sram_csb1;
  logic [9:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_dout1;

  t03_sram_ctrl dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int n_csb0 = 0;
  int n_csb1 = 0;

  // SRAM macro model: latch on posedge, data valid shortly after, garbage after next edge; writes commit on negedge.
  logic [31:0] mem [1024];
  logic [9:0]  rd_a, wr_a;
  logic [31:0] wr_d;
  bit          rd_pend = 0, wr_pend = 0;

  always @(posedge clk) begin
    rd_pend = !sram_csb1;
    if (!sram_csb1) rd_a = sram_addr1;
    if (!sram_csb0) begin
      wr_a = sram_addr0; wr_d = sram_din0; wr_pend = 1;
    end
    #1;
    sram_dout1 = rd_pend ? mem[rd_a] : 32'hBAD0_BAD0;
  end

  always @(negedge clk) begin
    if (wr_pend) begin
      mem[wr_a] = wr_d; wr_pend = 0;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] ref_mem [1024];
  logic [31:0] last_rd = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_expect(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel);
    exp_t e;
    int   lat;
    logic [9:0]  w;
    logic [31:0] v;
    w     = addr[11:2];
    e.err = 1'b0;
    if (addr[1:0] != 2'b00 || addr[31:12] != 20'h0) begin
      e.err = 1'b1; lat = 0;
    end else if (we && sel == 4'h0) begin
      lat = 0;
    end else if (we && sel == 4'hF) begin
      lat = 1; ref_mem[w] = wdata;
    end else if (we) begin
      lat = 3;
      v   = ref_mem[w];
      for (int b = 0; b < 4; b++) if (sel[b]) v[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[w] = v;
    end else begin
      lat = 2; last_rd = ref_mem[w];
    end
    e.rdata = last_rd;
    e.at    = cyc_n + 1 + lat;
    sb.push_back(e);
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, input bit expect_resp);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_sel = sel;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", {31'h0, req_ready}, 32'h1);
      req_valid = 0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 0; req_we = $urandom_range(0, 1); req_addr = $urandom;
    req_wdata = $urandom; req_sel = 4'($urandom);
    if (expect_resp) sb_expect(we, addr, wdata, sel);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  // Response monitor and per-cycle protocol checks.
  always @(negedge clk) begin
    exp_t e;
    cyc_n++;
    if (nrst) begin
      if (!sram_csb0) n_csb0++;
      if (!sram_csb1) n_csb1++;
      if (!sram_csb0 && !sram_csb1) check("csb_overlap", {sram_csb0, sram_csb1}, 2'b11);
      if (!resp_valid && resp_err) check("err_without_valid", resp_err, 0);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_resp", resp_valid, 0);
        end else begin
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", resp_err, e.err);
          check("resp_cycle", cyc_n, e.at);
        end
      end
    end
  end

  initial begin
    int c0, c1, w;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    nrst = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_sel = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_err", resp_err, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_csb", {sram_csb0, sram_csb1}, 2'b11);
    check("rst_addr", {sram_addr0, sram_addr1}, 0);
    check("rst_din0", sram_din0, 0);
    nrst = 1;
    @(posedge clk); #1;
    check("ready_after_rst", req_ready, 1);

    // Full write then read
    c0 = n_csb0; c1 = n_csb1;
    do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 1);
    do_req(0, 32'h10, 32'h0, 4'h0, 1);
    wait_drain();
    check("wr_rd_data", resp_rdata, 32'hDEADBEEF);
    check("wr_rd_csb0_cycles", n_csb0 - c0, 1);
    check("wr_rd_csb1_cycles", n_csb1 - c1, 1);

    // Partial RMW
    do_req(1, 32'h10, 32'h11223344, 4'hF, 1);
    wait_drain();
    c0 = n_csb0; c1 = n_csb1;
    do_req(1, 32'h10, 32'hAABBCCDD, 4'b0101, 1);
    wait_drain();
    check("rmw_csb0_cycles", n_csb0 - c0, 1);
    check("rmw_csb1_cycles", n_csb1 - c1, 1);
    do_req(0, 32'h10, 32'h0, 4'h0, 1);
    wait_drain();
    check("rmw_readback", resp_rdata, 32'h11BB33DD);

    // Errors: misaligned and out-of-window
    c0 = n_csb0; c1 = n_csb1;
    do_req(0, 32'h2, 32'h0, 4'h0, 1);
    do_req(0, 32'h1000, 32'h0, 4'h0, 1);
    wait_drain();
    check("err_no_csb", (n_csb0 - c0) + (n_csb1 - c1), 0);
    check("err_rdata_held", resp_rdata, 32'h11BB33DD);

    // sel=0 write leaves memory untouched
    do_req(1, 32'h20, 32'hCAFEF00D, 4'hF, 1);
    wait_drain();
    c0 = n_csb0;
    do_req(1, 32'h20, 32'h12345678, 4'h0, 1);
    wait_drain();
    check("sel0_no_csb0", n_csb0 - c0, 0);
    do_req(0, 32'h20, 32'h0, 4'h0, 1);
    wait_drain();
    check("sel0_readback", resp_rdata, 32'hCAFEF00D);

    // Random back-to-back stress
    for (int i = 0; i < 200; i++) begin
      w = $urandom_range(0, 15);
      case ($urandom_range(0, 9))
        0:       a = (32'(w) << 2) | 32'($urandom_range(1, 3));
        1:       a = 32'h1000 + (32'(w) << 2);
        default: a = 32'(w) << 2;
      endcase
      do_req($urandom_range(0, 1), a, $urandom, 4'($urandom), 1);
    end
    wait_drain();

    // Reset in the middle of an RMW
    do_req(1, 32'h10, 32'h0000_0000, 4'hF, 1);
    do_req(1, 32'h10, 32'h11BB33DD, 4'hF, 1);
    wait_drain();
    do_req(1, 32'h10, 32'hFFFFFFFF, 4'b0011, 0);
    @(posedge clk); #2;
    nrst = 0;
    #1;
    check("midrst_csb", {sram_csb0, sram_csb1}, 2'b11);
    check("midrst_valid", resp_valid, 0);
    repeat (3) @(negedge clk);
    check("midrst_mem", mem[4], 32'h11BB33DD);
    nrst = 1; last_rd = 32'h0;
    @(posedge clk); #1;
    check("midrst_ready", req_ready, 1);
    do_req(0, 32'h10, 32'h0, 4'h0, 1);
    wait_drain();
    check("midrst_readback", resp_rdata, 32'h11BB33DD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
